// File: rtl/suart_rx_frontend_pkg.sv
// Shared UART definitions (package ubsoc_uart_pkg), used by the RX front end
// and later by the TX block.
//   DATA_BITS   - payload bits per 8N1 frame
//   MIN_DIV     - smallest clocks-per-bit divisor that is honoured
//   DEFAULT_DIV - divisor used when the configured one is too small
//   rx_state_t  - receiver frame state
package ubsoc_uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned MIN_DIV     = 4;
  localparam int unsigned DEFAULT_DIV = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/suart_rx_frontend_if.sv
// Byte-stream handshake between the UART receive FIFO and the bus-side
// register logic.
//   data_o       - FIFO head byte
//   valid_o      - FIFO non-empty
//   ready_i      - consumer takes the head byte when valid_o && ready_i
//   fifo_level_o - current entry count
// master: the receive front end; slave: the consumer.
interface suart_rx_frontend_if
  import ubsoc_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 ready_i;
  logic [LVL_W-1:0]     fifo_level_o;

  modport master (output data_o, valid_o, fifo_level_o, input ready_i);
  modport slave  (input data_o, valid_o, fifo_level_o, output ready_i);
endinterface

// File: rtl/suart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is read straight
// out of storage, so dout_o is valid in the same cycle as !empty_o.
//   clk_i, rst_i - clock, synchronous active-high reset
//   push_i/din_i - write; accepted when not full, or full with a pop
//   pop_i        - read; ignored while empty
//   dout_o       - head entry
//   full_o, empty_o, level_o - status
module suart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == (PW+1)'(DEPTH));
  assign level_o = count;
  assign dout_o  = mem[rd_ptr];

  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the slot being written (wr_ptr == rd_ptr).
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/suart_rx_frontend.sv
// UART receive front end: oversamples rx_i, decodes 8N1 frames, queues bytes
// in a small FIFO and hands them out over a valid/ready interface.
//   clk_i, rst_i - clock, synchronous active-high reset
//   rx_i         - asynchronous serial input, idles high
//   cfg_div_i    - clocks per bit (DEFAULT_DIV used below MIN_DIV)
//   rx_bus       - byte handshake (data/valid/ready/level), master side
//   busy_o       - frame in progress
//   frame_err_o  - sticky, stop bit sampled low
//   overrun_o    - sticky, byte dropped on a full FIFO
//   clr_err_i    - clears both sticky flags (a same-cycle set wins)
module suart_rx_frontend #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = ubsoc_uart_pkg::DEFAULT_DIV,
  parameter int unsigned MIN_DIV     = ubsoc_uart_pkg::MIN_DIV
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rx_i,
  input  logic [31:0]        cfg_div_i,
  suart_rx_frontend_if.master rx_bus,
  output logic               busy_o,
  output logic               frame_err_o,
  output logic               overrun_o,
  input  logic               clr_err_i
);
  import ubsoc_uart_pkg::*;

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 sync1, sync2, prev;
  logic                 cur, fall;
  logic [31:0]          div_sel, div_q, cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  rx_state_t            state;
  logic                 stop_fire, pop, full, empty, push, ovr_set, fe_set;
  logic [LVL_W-1:0]     level;

  // Sync flops reset high so releasing reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign cur     = sync2;
  assign fall    = prev && !cur;
  assign div_sel = (cfg_div_i < MIN_DIV) ? 32'(DEFAULT_DIV) : cfg_div_i;
  assign busy_o  = (state != IDLE);

  assign stop_fire = (state == STOP) && (cnt == '0);
  assign pop       = rx_bus.valid_o && rx_bus.ready_i;
  assign push      = stop_fire && cur && (!full || pop);
  assign ovr_set   = stop_fire && cur && full && !pop;
  assign fe_set    = stop_fire && !cur;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= 32'(DEFAULT_DIV);
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            div_q <= div_sel;
            cnt   <= (div_sel >> 1) - 32'd1;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!cur) begin
              cnt     <= div_q - 32'd1;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg   <= {cur, shreg[DATA_BITS-1:1]};
            cnt     <= div_q - 32'd1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (fe_set)         frame_err_o <= 1'b1;
      else if (clr_err_i) frame_err_o <= 1'b0;
      if (ovr_set)        overrun_o   <= 1'b1;
      else if (clr_err_i) overrun_o   <= 1'b0;
    end
  end

  suart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (shreg),
    .pop_i   (rx_bus.ready_i),
    .dout_o  (rx_bus.data_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign rx_bus.valid_o      = !empty;
  assign rx_bus.fifo_level_o = level;
endmodule

// File: tb/tb_suart_rx_frontend.sv
module tb_suart_rx_frontend;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] cfg_div = 32'd434;
  logic        busy, ferr, ovr;

  int checks = 0;
  int errors = 0;

  suart_rx_frontend_if #(.FIFO_DEPTH(4)) bus ();

  suart_rx_frontend #(
    .FIFO_DEPTH  (4),
    .DEFAULT_DIV (434),
    .MIN_DIV     (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .cfg_div_i   (cfg_div),
    .rx_bus      (bus.master),
    .busy_o      (busy),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .clr_err_i   (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Advance n clocks; inputs change and outputs are read 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int d, input logic stop_bit);
    rx = 1'b0;
    tick(d);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(d);
    end
    rx = stop_bit;
    tick(d);
  endtask

  task automatic pop_one(output logic [7:0] d);
    d = bus.data_o;
    bus.ready_i = 1'b1;
    tick(1);
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b0;
    tick(2);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level_o); end
    checks++; if (bus.data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data_o); end
    checks++; if ({busy, ferr, ovr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, ferr, ovr}); end
    rst = 1'b0;
    rx  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (busy !== 1'b0) begin
        checks++; errors++;
        $display("FAIL reset_idle_busy: got %b want 0 at cycle %0d", busy, i);
        break;
      end
    end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_nominal;
    int lat;
    bit found;
    logic [7:0] d;
    cfg_div = 32'd434;
    lat = 0;
    found = 1'b0;
    fork
      send_frame(8'h0D, 434, 1'b1);
      begin
        for (int n = 1; n <= 5000 && !found; n++) begin
          @(posedge clk); #1;
          if (bus.valid_o === 1'b1) begin found = 1'b1; lat = n; end
        end
      end
    join
    checks++; if (!found) begin errors++; $display("FAIL nominal_timeout: valid_o never rose within 5000 cycles"); end
    checks++; if (lat < 4121 || lat > 4127) begin errors++; $display("FAIL nominal_latency: got %0d want 4124+-3", lat); end
    checks++; if (bus.data_o !== 8'h0D) begin errors++; $display("FAIL nominal_data: got %h want 0d", bus.data_o); end
    checks++; if (bus.fifo_level_o !== 3'd1) begin errors++; $display("FAIL nominal_level: got %0d want 1", bus.fifo_level_o); end
    pop_one(d);
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL nominal_pop_valid: got %b want 0", bus.valid_o); end
    checks++; if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL nominal_pop_level: got %0d want 0", bus.fifo_level_o); end
  endtask

  task automatic test_burst_overrun;
    logic [7:0] tx [5];
    logic [7:0] d;
    tx = '{8'h34, 8'h31, 8'h32, 8'h33, 8'h35};
    cfg_div = 32'd16;
    for (int i = 0; i < 5; i++) send_frame(tx[i], 16, 1'b1);
    checks++; if (bus.fifo_level_o !== 3'd4) begin errors++; $display("FAIL burst_level: got %0d want 4", bus.fifo_level_o); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL burst_overrun: got %b want 1", ovr); end
    for (int i = 0; i < 4; i++) begin
      pop_one(d);
      checks++; if (d !== tx[i]) begin errors++; $display("FAIL burst_pop%0d: got %h want %h", i, d, tx[i]); end
    end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL burst_drained: got %b want 0", bus.valid_o); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL burst_ovr_clear: got %b want 0", ovr); end
  endtask

  task automatic test_back_to_back_pop;
    logic [7:0] tx [5];
    logic [7:0] exp_q [4];
    logic [7:0] d;
    logic [7:0] popped;
    tx    = '{8'h34, 8'h31, 8'h32, 8'h33, 8'h35};
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h35};
    cfg_div = 32'd16;
    popped = 8'h00;
    for (int i = 0; i < 4; i++) send_frame(tx[i], 16, 1'b1);
    // The stop sample of a div-16 frame lands 155 clocks after its falling edge.
    fork
      send_frame(tx[4], 16, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1;
        popped = bus.data_o;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b0;
      end
    join
    checks++; if (popped !== 8'h34) begin errors++; $display("FAIL b2b_popped: got %h want 34", popped); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", ovr); end
    checks++; if (bus.fifo_level_o !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d want 4", bus.fifo_level_o); end
    for (int i = 0; i < 4; i++) begin
      pop_one(d);
      checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL b2b_pop%0d: got %h want %h", i, d, exp_q[i]); end
    end
  endtask

  task automatic test_glitch_framing;
    cfg_div = 32'd434;
    rx = 1'b0;
    tick(50);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %b want 1", busy); end
    tick(50);
    rx = 1'b1;
    tick(130);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b want 0", busy); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL glitch_push: got %b want 0", bus.valid_o); end

    cfg_div = 32'd16;
    send_frame(8'h55, 16, 1'b0);
    tick(48);
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b want 1", ferr); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL frame_no_push: got %b want 0", bus.valid_o); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_break_busy: got %b want 0", busy); end
    rx = 1'b1;
    tick(16);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b want 0", ferr); end
  endtask

  task automatic test_divisor;
    logic [7:0] d;
    cfg_div = 32'd2;
    fork
      send_frame(8'hA5, 434, 1'b1);
      begin
        tick(2000);
        cfg_div = 32'd217;
      end
    join
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL div_default_valid: got %b want 1", bus.valid_o); end
    pop_one(d);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL div_default_data: got %h want a5", d); end
    send_frame(8'h5A, 217, 1'b1);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL div_change_valid: got %b want 1", bus.valid_o); end
    pop_one(d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL div_change_data: got %h want 5a", d); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    cfg_div = 32'd64;
    rx = 1'b0;
    tick(64);
    rx = 1'b1;
    tick(64 * 4 + 32);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    tick(64 * 7);
    checks++; if (bus.fifo_level_o !== 3'd0) begin errors++; $display("FAIL midrst_level: got %0d want 0", bus.fifo_level_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.valid_o); end
    send_frame(8'h41, 64, 1'b1);
    checks++; if (bus.fifo_level_o !== 3'd1) begin errors++; $display("FAIL midrst_next_level: got %0d want 1", bus.fifo_level_o); end
    pop_one(d);
    checks++; if (d !== 8'h41) begin errors++; $display("FAIL midrst_next_data: got %h want 41", d); end
  endtask

  initial begin
    bus.ready_i = 1'b0;
    test_reset();
    test_nominal();
    test_burst_overrun();
    test_back_to_back_pop();
    test_glitch_framing();
    test_divisor();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
